// File: rtl/reset_seq_pkg.sv
// Shared state encoding and sizing helper for the reset sequencer.
// Imported by the sequencer top level.
package reset_seq_pkg;

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int clog2_max(int a, int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-assert, sync-deassert reset synchronizer.
// Shifts a constant 1 through SYNC_STAGES flops.
module reset_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Stretches a synchronized reset release, then frees reset domains
// one at a time; also services a synchronous software reset request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 4,
  parameter int NUM_OUT     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               rst_done,
  output logic               rst_busy
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("STEP_CYCLES must be >= 1");
  end
  if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_num
    $error("NUM_OUT must be 1..16");
  end

  localparam int CW = clog2_max(HOLD_CYCLES, STEP_CYCLES);
  localparam int IW = $clog2(NUM_OUT + 1);

  // Power-up entry happens one edge later than a software request,
  // so it loads one less to land on the same release edge.
  localparam logic [CW-1:0] HOLD_SW = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_PU = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LD = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_OUT - 1);

  logic               rst_sync;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_dec;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
  logic               done_q, done_d;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .rst_sync(rst_sync)
  );

  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    if (state_q != ST_RST && sw_rst_req) begin
      state_d = ST_HOLD;
      cnt_d   = HOLD_SW;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (rst_sync) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_PU;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            rst_n_d[0] = 1'b1;
            cnt_d      = STEP_LD;
            if (NUM_OUT == 1) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_REL;
              idx_d   = IW'(1);
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        ST_REL: begin
          if (cnt_q == '0) begin
            for (int k = 0; k < NUM_OUT; k++) begin
              if (idx_q == IW'(k)) rst_n_d[k] = 1'b1;
            end
            cnt_d = STEP_LD;
            idx_d = idx_q + IW'(1);
            if (idx_q == LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        ST_DONE: ;
        default: state_d = ST_RST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  assign rst_n_out = rst_n_q;
  assign rst_done  = done_q;
  assign rst_busy  = ~done_q;

endmodule
